// File: rtl/cla_pipe_adder_if.sv
// Operand/result handshake bundle for the pipelined CLA adder.
// The master drives operands and out_ready; the slave is the adder.
interface cla_pipe_adder_if #(
    parameter int WIDTH = 32,
    parameter int TAGW  = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_sub;
    logic [TAGW-1:0]  in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;
    logic             out_zero;
    logic [TAGW-1:0]  out_tag;

    modport master (
        output in_valid, in_a, in_b, in_cin, in_sub, in_tag, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero, out_tag
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_sub, in_tag, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero, out_tag
    );
endinterface

// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor: stage 1 registers per-block
// P/G and carry-select sums, stage 2 resolves block carries with flat lookahead.
module cla_blk #(
    parameter int BLOCK = 8
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] bx,
    output logic             p,
    output logic             g,
    output logic [BLOCK-1:0] sum0,
    output logic [BLOCK-1:0] sum1
);
    assign p        = &(a ^ bx);
    assign {g, sum0} = {1'b0, a} + {1'b0, bx};
    assign sum1     = sum0 + BLOCK'(1);
endmodule

module cla_pipe_adder #(
    parameter int WIDTH = 32,
    parameter int BLOCK = 8,
    parameter int TAGW  = 5
) (
    input  logic               clock,
    input  logic               reset,
    cla_pipe_adder_if.slave    io
);
    localparam int NBLK = WIDTH / BLOCK;

    if (WIDTH % BLOCK != 0) begin : g_cfg_err
        $error("cla_pipe_adder: WIDTH must be a multiple of BLOCK");
    end

    typedef struct packed {
        logic [NBLK-1:0]            p;
        logic [NBLK-1:0]            g;
        logic [NBLK-1:0][BLOCK-1:0] sum0;
        logic [NBLK-1:0][BLOCK-1:0] sum1;
        logic                       c0;
        logic                       a_msb;
        logic                       bx_msb;
        logic [TAGW-1:0]            tag;
    } stage_t;

    logic [WIDTH-1:0]           bx;
    logic [NBLK-1:0]            blk_p, blk_g;
    logic [NBLK-1:0][BLOCK-1:0] blk_s0, blk_s1;
    stage_t                     s1_d, s1_q, s2_d, s2_q;
    logic                       s1_valid_d, s1_valid_q, s2_valid_d, s2_valid_q;
    logic                       adv1, adv2;
    logic [NBLK:0]              c;
    logic [NBLK-1:0][BLOCK-1:0] sum;
    logic [WIDTH-1:0]           sum_flat;

    assign bx = io.in_sub ? ~io.in_b : io.in_b;

    for (genvar k = 0; k < NBLK; k++) begin : g_blk
        cla_blk #(.BLOCK(BLOCK)) u_blk (
            .a    (io.in_a[k*BLOCK +: BLOCK]),
            .bx   (bx[k*BLOCK +: BLOCK]),
            .p    (blk_p[k]),
            .g    (blk_g[k]),
            .sum0 (blk_s0[k]),
            .sum1 (blk_s1[k])
        );
    end

    // in_ready is combinational from out_ready so a full pipe can still stream.
    assign adv2        = !s2_valid_q || io.out_ready;
    assign adv1        = !s1_valid_q || adv2;
    assign io.in_ready = adv1;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        s2_valid_d = s2_valid_q;
        s2_d       = s2_q;
        if (adv1) begin
            s1_valid_d  = io.in_valid;
            s1_d.p      = blk_p;
            s1_d.g      = blk_g;
            s1_d.sum0   = blk_s0;
            s1_d.sum1   = blk_s1;
            s1_d.c0     = io.in_sub | io.in_cin;
            s1_d.a_msb  = io.in_a[WIDTH-1];
            s1_d.bx_msb = bx[WIDTH-1];
            s1_d.tag    = io.in_tag;
        end
        if (adv2) begin
            s2_valid_d = s1_valid_q;
            s2_d       = s1_q;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_q       <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
        end
    end

    // Each block carry is a two-level sum of products: no ripple between blocks.
    always_comb begin
        logic term, cy;
        term = 1'b0;
        cy   = 1'b0;
        c    = '0;
        c[0] = s2_q.c0;
        for (int k = 0; k < NBLK; k++) begin
            cy = s2_q.c0;
            for (int m = 0; m <= k; m++) cy = cy & s2_q.p[m];
            for (int j = 0; j <= k; j++) begin
                term = s2_q.g[j];
                for (int m = j + 1; m <= k; m++) term = term & s2_q.p[m];
                cy = cy | term;
            end
            c[k+1] = cy;
        end
    end

    always_comb begin
        sum = '0;
        for (int k = 0; k < NBLK; k++)
            sum[k] = c[k] ? s2_q.sum1[k] : s2_q.sum0[k];
    end

    assign sum_flat     = sum;
    assign io.out_valid = s2_valid_q;
    assign io.out_sum   = sum_flat;
    assign io.out_cout  = c[NBLK];
    assign io.out_ovf   = (s2_q.a_msb == s2_q.bx_msb) && (sum_flat[WIDTH-1] != s2_q.a_msb);
    // Qualified by valid so the all-zero reset datapath does not read as a zero result.
    assign io.out_zero  = s2_valid_q & ~|sum_flat;
    assign io.out_tag   = s2_q.tag;
endmodule
